// File: rtl/xbar_pkg.sv
// Shared types and width helpers for the crossbar arbiter.
package xbar_pkg;

  typedef enum logic {StIdle, StBusy} arb_state_e;

  // Widths never collapse to zero so single-port configurations still elaborate.
  function automatic int dest_width(int m_count);
    return (m_count > 1) ? $clog2(m_count) : 1;
  endfunction

  function automatic int src_width(int s_count);
    return (s_count > 1) ? $clog2(s_count) : 1;
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Per-sink arbiter: packet-locked grant, round-robin under conflict, lowest-index otherwise.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int S_DATA_COUNT = 2,
  parameter int T_SRC_WIDTH  = src_width(S_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_COUNT-1:0] req_i,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic                    conflict_i,
  input  logic                    m_ready_i,
  output logic                    m_valid_o,
  output logic                    busy_o,
  output logic [T_SRC_WIDTH-1:0]  sel_o,
  output logic [S_DATA_COUNT-1:0] grant_o
);

  arb_state_e             state_q, state_d;
  logic [T_SRC_WIDTH-1:0] ptr_q, ptr_d;
  logic [T_SRC_WIDTH-1:0] sel_q, sel_d;
  logic [T_SRC_WIDTH-1:0] low_idx, rr_idx;
  logic                   rr_found;

  always_comb begin
    low_idx = '0;
    for (int i = S_DATA_COUNT - 1; i >= 0; i--) begin
      if (req_i[i]) low_idx = T_SRC_WIDTH'(i);
    end
    // Search starts one past the previous winner and wraps.
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= S_DATA_COUNT; k++) begin
      if (!rr_found && req_i[(int'(ptr_q) + k) % S_DATA_COUNT]) begin
        rr_idx   = T_SRC_WIDTH'((int'(ptr_q) + k) % S_DATA_COUNT);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StBusy;
          if (conflict_i) begin
            sel_d = rr_idx;
            ptr_d = rr_idx;
          end else begin
            sel_d = low_idx;
          end
        end
      end
      StBusy: begin
        if (s_valid_i[sel_q] && m_ready_i && s_last_i[sel_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= T_SRC_WIDTH'(S_DATA_COUNT - 1);
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  // Outputs are forced quiet for the whole time reset is held.
  always_comb begin
    busy_o    = !rst && (state_q == StBusy);
    m_valid_o = busy_o && s_valid_i[sel_q];
    sel_o     = rst ? '0 : sel_q;
    grant_o   = busy_o ? (S_DATA_COUNT'(1) << sel_q) : '0;
  end

endmodule

// File: rtl/xbar_arbiter.sv
// Crossbar arbitration stage: one packet-locked arbiter per sink plus source-side fan-in.
module xbar_arbiter
  import xbar_pkg::*;
#(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT),
  localparam int T_SRC_WIDTH  = src_width(S_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [M_DATA_COUNT-1:0]              conflict_i,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  output logic [M_DATA_COUNT*T_SRC_WIDTH-1:0]  m_sel_o,
  output logic [M_DATA_COUNT-1:0]              m_busy_o
);

  logic [S_DATA_COUNT-1:0] req   [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] grant [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] src_busy;

  always_comb begin
    src_busy = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) src_busy |= grant[m];
  end

  // A source already locked to a sink cannot request anywhere else.
  always_comb begin
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      for (int i = 0; i < S_DATA_COUNT; i++) begin
        req[m][i] = s_valid_i[i] && !src_busy[i] &&
                    (s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(m));
      end
    end
  end

  always_comb begin
    s_ready_o = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      s_ready_o |= grant[m] & {S_DATA_COUNT{m_ready_i[m]}};
    end
  end

  for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_sink
    xbar_rr_arbiter #(
      .S_DATA_COUNT(S_DATA_COUNT),
      .T_SRC_WIDTH (T_SRC_WIDTH)
    ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req[m]),
      .s_valid_i (s_valid_i),
      .s_last_i  (s_last_i),
      .conflict_i(conflict_i[m]),
      .m_ready_i (m_ready_i[m]),
      .m_valid_o (m_valid_o[m]),
      .busy_o    (m_busy_o[m]),
      .sel_o     (m_sel_o[m*T_SRC_WIDTH +: T_SRC_WIDTH]),
      .grant_o   (grant[m])
    );
  end

endmodule

// File: tb/tb_xbar_arbiter.sv
// Directed scenarios plus randomized traffic checked against a rule-level model of the arbiter.
module tb_xbar_arbiter;

  localparam int S  = 2;
  localparam int M  = 3;
  localparam int DW = $clog2(M);
  localparam int SW = $clog2(S);

  logic            clk = 1'b0;
  logic            rst;
  logic [S-1:0]    s_valid, s_last, s_ready;
  logic [S*DW-1:0] s_dest;
  logic [M-1:0]    conflict, m_ready, m_valid, m_busy;
  logic [M*SW-1:0] m_sel;

  int total = 0;
  int bad   = 0;

  // Model state: per-sink lock flag, locked source, round-robin pointer.
  int mb[M];
  int ms[M];
  int mp[M];

  xbar_arbiter #(.S_DATA_COUNT(S), .M_DATA_COUNT(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (s_valid),
    .s_last_i  (s_last),
    .s_dest_i  (s_dest),
    .conflict_i(conflict),
    .m_ready_i (m_ready),
    .s_ready_o (s_ready),
    .m_valid_o (m_valid),
    .m_sel_o   (m_sel),
    .m_busy_o  (m_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  function automatic int sel_of(int m);
    return int'(m_sel[m*SW +: SW]);
  endfunction

  function automatic int dest_of(int i);
    return int'(s_dest[i*DW +: DW]);
  endfunction

  task automatic set_dest(int i, int d);
    s_dest[i*DW +: DW] = DW'(d);
  endtask

  // Applies the arbitration rules to the inputs present at this edge.
  task automatic model_update();
    int nb[M], ns[M], np[M];
    if (rst) begin
      for (int m = 0; m < M; m++) begin mb[m] = 0; ms[m] = 0; mp[m] = S - 1; end
      return;
    end
    for (int m = 0; m < M; m++) begin nb[m] = mb[m]; ns[m] = ms[m]; np[m] = mp[m]; end
    for (int m = 0; m < M; m++) begin
      if (mb[m] != 0) begin
        if (s_valid[ms[m]] && m_ready[m] && s_last[ms[m]]) nb[m] = 0;
      end else begin
        int cand[$];
        for (int i = 0; i < S; i++) begin
          bit taken = 0;
          for (int m2 = 0; m2 < M; m2++) if (mb[m2] != 0 && ms[m2] == i) taken = 1;
          if (s_valid[i] && dest_of(i) == m && !taken) cand.push_back(i);
        end
        if (cand.size() > 0) begin
          int w = cand[0];
          if (conflict[m]) begin
            for (int k = S; k >= 1; k--) begin
              int c = (mp[m] + k) % S;
              foreach (cand[j]) if (cand[j] == c) w = c;
            end
            np[m] = w;
          end
          ns[m] = w;
          nb[m] = 1;
        end
      end
    end
    for (int m = 0; m < M; m++) begin mb[m] = nb[m]; ms[m] = ns[m]; mp[m] = np[m]; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    s_valid = '0; s_last = '0; s_dest = '0; conflict = '0; m_ready = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_idle(); tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_idle(); s_valid = '1; s_last = '1; conflict = '1;
    #1;
    total++; if (m_busy !== 3'b000) begin bad++; $display("FAIL rst_busy: got %b want 000", m_busy); end
    total++; if (m_valid !== 3'b000) begin bad++; $display("FAIL rst_valid: got %b want 000", m_valid); end
    total++; if (s_ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", s_ready); end
    tick(); tick();
    total++; if (m_sel !== '0) begin bad++; $display("FAIL rst_sel: got %h want 0", m_sel); end
    rst = 1'b0; drive_idle(); #1;
    total++; if (m_busy !== 3'b000) begin bad++; $display("FAIL post_rst_busy: got %b want 000", m_busy); end
  endtask

  task automatic test_single_packet();
    do_reset();
    s_valid = 2'b01; set_dest(0, 1); #1;
    total++; if (m_valid !== 3'b000 || s_ready !== 2'b00) begin
      bad++; $display("FAIL arb_cycle: got v=%b r=%b want v=000 r=00", m_valid, s_ready);
    end
    tick();
    for (int b = 0; b < 3; b++) begin
      s_last = (b == 2) ? 2'b01 : 2'b00; #1;
      total++; if (m_busy !== 3'b010 || m_valid !== 3'b010 || s_ready !== 2'b01 || sel_of(1) != 0) begin
        bad++; $display("FAIL pkt_beat%0d: got b=%b v=%b r=%b sel=%0d want b=010 v=010 r=01 sel=0",
                        b, m_busy, m_valid, s_ready, sel_of(1));
      end
      tick();
    end
    drive_idle(); #1;
    total++; if (m_busy !== 3'b000 || m_valid !== 3'b000) begin
      bad++; $display("FAIL pkt_release: got b=%b v=%b want 000", m_busy, m_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      s_valid = 2'b11; set_dest(0, 2); set_dest(1, 2); conflict = 3'b100; s_last = '0; #1;
      total++; if (m_busy[2] !== 1'b0) begin bad++; $display("FAIL rr_bubble%0d: got %b want 0", p, m_busy[2]); end
      tick();
      for (int b = 0; b < 2; b++) begin
        s_last = (b == 1) ? 2'b11 : 2'b00; #1;
        total++; if (sel_of(2) != p % 2 || s_ready !== 2'(1 << (p % 2)) || m_valid[2] !== 1'b1) begin
          bad++; $display("FAIL rr_pkt%0d_beat%0d: got sel=%0d r=%b v=%b want sel=%0d",
                          p, b, sel_of(2), s_ready, m_valid[2], p % 2);
        end
        tick();
      end
    end
    drive_idle(); tick();
  endtask

  task automatic test_parallel();
    do_reset();
    s_valid = 2'b11; set_dest(0, 0); set_dest(1, 2); tick();
    total++; if (m_busy !== 3'b101 || m_valid !== 3'b101 || sel_of(0) != 0 || sel_of(2) != 1 || s_ready !== 2'b11) begin
      bad++; $display("FAIL par_grant: got b=%b v=%b s0=%0d s2=%0d r=%b want b=101 v=101 s0=0 s2=1 r=11",
                      m_busy, m_valid, sel_of(0), sel_of(2), s_ready);
    end
    m_ready = 3'b001; s_valid = 2'b01; #1;
    total++; if (m_valid !== 3'b001 || s_ready !== 2'b01 || m_busy !== 3'b101) begin
      bad++; $display("FAIL par_indep: got v=%b r=%b b=%b want v=001 r=01 b=101", m_valid, s_ready, m_busy);
    end
    s_valid = 2'b11; s_last = 2'b11; m_ready = '1; tick();
    drive_idle(); #1;
    total++; if (m_busy !== 3'b000) begin bad++; $display("FAIL par_release: got %b want 000", m_busy); end
  endtask

  task automatic test_stall();
    int beats = 0;
    do_reset();
    s_valid = 2'b10; set_dest(1, 1); s_last = 2'b10; m_ready = '0; tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (s_ready !== 2'b00 || m_busy[1] !== 1'b1 || m_valid[1] !== 1'b1) begin
        bad++; $display("FAIL stall%0d: got r=%b b=%b v=%b want r=00 b=1 v=1", c, s_ready, m_busy[1], m_valid[1]);
      end
      if (s_ready[1] && m_valid[1]) beats++;
      tick();
    end
    m_ready = '1; #1;
    total++; if (s_ready !== 2'b10) begin bad++; $display("FAIL stall_resume: got %b want 10", s_ready); end
    if (s_ready[1] && m_valid[1]) beats++;
    tick();
    total++; if (beats != 1) begin bad++; $display("FAIL stall_beats: got %0d want 1", beats); end
    drive_idle(); #1;
    total++; if (m_busy !== 3'b000) begin bad++; $display("FAIL stall_release: got %b want 000", m_busy); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    // Move sink 0's pointer to source 0 so a kept pointer would pick source 1 next.
    s_valid = 2'b01; set_dest(0, 0); s_last = 2'b01; conflict = 3'b001; tick(); tick();
    drive_idle(); tick();
    s_valid = 2'b01; set_dest(0, 1); tick(); tick();
    rst = 1'b1; #1;
    total++; if (m_busy !== 3'b000 || s_ready !== 2'b00) begin
      bad++; $display("FAIL mid_rst: got b=%b r=%b want b=000 r=00", m_busy, s_ready);
    end
    tick(); rst = 1'b0; drive_idle(); #1;
    total++; if (m_busy !== 3'b000) begin bad++; $display("FAIL mid_rst_after: got %b want 000", m_busy); end
    s_valid = 2'b11; set_dest(0, 0); set_dest(1, 0); conflict = 3'b001; tick();
    total++; if (m_busy[0] !== 1'b1 || sel_of(0) != 0) begin
      bad++; $display("FAIL mid_rst_ptr: got b=%b sel=%0d want b=1 sel=0", m_busy[0], sel_of(0));
    end
    s_last = 2'b11; tick(); drive_idle(); tick(); tick();
  endtask

  task automatic test_dest_change();
    do_reset();
    s_valid = 2'b01; set_dest(0, 1); tick();
    set_dest(0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (m_busy !== 3'b010 || sel_of(1) != 0) begin
        bad++; $display("FAIL dest_chg%0d: got b=%b sel=%0d want b=010 sel=0", c, m_busy, sel_of(1));
      end
      tick();
    end
    s_last = 2'b01; tick(); s_last = '0; #1;
    total++; if (m_busy !== 3'b000) begin bad++; $display("FAIL dest_chg_gap: got %b want 000", m_busy); end
    tick();
    total++; if (m_busy !== 3'b001 || sel_of(0) != 0) begin
      bad++; $display("FAIL dest_chg_regrant: got b=%b sel=%0d want b=001 sel=0", m_busy, sel_of(0));
    end
    s_last = 2'b01; tick(); drive_idle(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [M-1:0] ev, eb;
      logic [S-1:0] er;
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < S; i++) begin
        s_valid[i] = ($urandom_range(0, 3) != 0);
        s_last[i]  = ($urandom_range(0, 2) == 0);
        set_dest(i, $urandom_range(0, M - 1));
      end
      for (int m = 0; m < M; m++) begin
        conflict[m] = $urandom_range(0, 1) == 1;
        m_ready[m]  = ($urandom_range(0, 9) < 7);
      end
      #1;
      er = '0;
      for (int m = 0; m < M; m++) begin
        eb[m] = !rst && mb[m] != 0;
        ev[m] = eb[m] && s_valid[ms[m]];
        if (eb[m] && m_ready[m]) er[ms[m]] = 1'b1;
        total++; if (sel_of(m) != (rst ? 0 : ms[m])) begin
          bad++; $display("FAIL rnd_sel c=%0d m=%0d: got %0d want %0d", c, m, sel_of(m), rst ? 0 : ms[m]);
        end
      end
      total++; if (m_busy !== eb) begin bad++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, m_busy, eb); end
      total++; if (m_valid !== ev) begin bad++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, m_valid, ev); end
      total++; if (s_ready !== er) begin bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, s_ready, er); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < M; m++) begin mb[m] = 0; ms[m] = 0; mp[m] = S - 1; end
    test_reset();
    test_single_packet();
    test_round_robin();
    test_parallel();
    test_stall();
    test_reset_mid_packet();
    test_dest_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xbar_arbiter.md
XBAR_ARBITER -- requirements
Module: xbar_arbiter

Interface
REQ-001 Parameter S_DATA_COUNT, default 2: number of master (source) ports.
REQ-002 Parameter M_DATA_COUNT, default 3: number of slave (sink) ports.
REQ-003 Localparams T_DEST_WIDTH = $clog2(M_DATA_COUNT) and T_SRC_WIDTH = $clog2(S_DATA_COUNT).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 s_valid_i  input  [S_DATA_COUNT-1:0]  per-source TVALID.
REQ-007 s_last_i  input  [S_DATA_COUNT-1:0]  per-source TLAST.
REQ-008 s_dest_i  input  [T_DEST_WIDTH-1:0] x S_DATA_COUNT  per-source destination port.
REQ-009 conflict_i  input  [M_DATA_COUNT-1:0]  per-sink flag from the upstream conflict stage: at least two sources target this sink.
REQ-010 m_ready_i  input  [M_DATA_COUNT-1:0]  per-sink TREADY.
REQ-011 s_ready_o  output  [S_DATA_COUNT-1:0]  per-source TREADY.
REQ-012 m_valid_o  output  [M_DATA_COUNT-1:0]  per-sink TVALID.
REQ-013 m_sel_o  output  [T_SRC_WIDTH-1:0] x M_DATA_COUNT  source index routed to each sink.
REQ-014 m_busy_o  output  [M_DATA_COUNT-1:0]  sink is locked to a source for a packet.

Function
REQ-015 Each sink m SHALL run an independent two-state FSM: IDLE, BUSY.
REQ-016 Requesters of sink m: sources i with s_valid_i[i]=1 and s_dest_i[i]=m that are not currently granted on any sink.
REQ-017 IDLE, no requester: stay IDLE.
REQ-018 IDLE, requesters present, conflict_i[m]=1: the winner is the first requester found searching from ptr[m]+1 upward, wrapping modulo S_DATA_COUNT. Register m_sel_o[m] = winner, set ptr[m] = winner, go BUSY.
REQ-019 IDLE, requesters present, conflict_i[m]=0: the winner is the lowest-index requester. ptr[m] is unchanged; go BUSY.
REQ-020 The grant takes effect the cycle after arbitration (1-cycle latency). No data is passed in the arbitration cycle.
REQ-021 BUSY: m_valid_o[m] = s_valid_i[sel] and s_ready_o[sel] = m_ready_i[m], combinationally. s_dest_i[sel] is ignored until release.
REQ-022 BUSY -> IDLE on a beat where s_valid_i[sel], m_ready_i[m] and s_last_i[sel] are all 1. Re-arbitration happens in the following cycle (1-cycle bubble between packets).
REQ-023 A single-beat packet (s_last_i=1 on its first beat) SHALL release after that one beat.
REQ-024 While BUSY, a granted source that drops s_valid_i SHALL keep its grant; m_valid_o follows it to 0.
REQ-025 A source not granted on any sink SHALL see s_ready_o=0.
REQ-026 In IDLE, m_valid_o[m]=0, m_busy_o[m]=0, and m_sel_o[m] holds its last value.
REQ-027 Two sinks SHALL never select the same source; REQ-016 guarantees this.
REQ-028 When several sinks are IDLE in the same cycle, they arbitrate independently. Each source targets one sink, so no cross-sink collision occurs.

Reset
REQ-029 While rst=1, all FSMs go to IDLE; ptr[m] = S_DATA_COUNT-1; m_sel_o = 0; m_busy_o = 0; m_valid_o = 0; s_ready_o = 0.
REQ-030 Reset asserted mid-packet SHALL drop the grant at the next edge. The partial packet is not completed.
REQ-031 The first arbitration after reset with conflict_i=1 SHALL favour source 0.

Structure
REQ-032 Package xbar_pkg SHALL hold the width helper functions (dest/src width from counts) and the FSM state enum (IDLE, BUSY).
REQ-033 Per-sink logic SHALL be one sub-module, xbar_rr_arbiter: FSM, ptr and sel for a single sink. It is instantiated M_DATA_COUNT times in a generate loop.
REQ-034 The top level SHALL hold only the requester masks, the busy-source OR-reduction and the s_ready_o fan-in.

Verification
REQ-035 Reset, then src0 dest=1 with a 3-beat packet, m_ready=1, conflict=0 -> grant at cycle 2; m_valid_o[1] high for 3 beats; m_sel_o[1]=0; IDLE after last beat.
REQ-036 src0 and src1 both dest=2, conflict_i[2]=1, continuous 2-beat packets -> grants alternate 0,1,0,1; one bubble cycle between packets.
REQ-037 src0 dest=0 and src1 dest=2 simultaneously -> both granted in the same cycle; independent m_valid_o[0] and m_valid_o[2].
REQ-038 Granted src1 with m_ready_i=0 for 4 cycles, then 1 -> s_ready_o[1]=0 during the stall; no beat lost; release only on the last-beat handshake.
REQ-039 rst asserted on beat 2 of a 5-beat packet -> next cycle all m_busy_o=0, s_ready_o=0, ptr reset; the next conflicting arbitration picks src0.
REQ-040 Granted src0 changes s_dest_i mid-packet from 1 to 0 -> m_sel_o[1] stays 0; sink 0 gets no grant until sink 1 releases.
